// File: rtl/jump_cfg_pkg.sv
// Shared definitions for the jump-table configuration loader.
package jump_cfg_pkg;

    localparam int JW       = 5;
    localparam int NF       = 5;
    localparam int CFG_BITS = JW * NF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Field 0 (jump1) holds the first bits received, so it sits at the top of the shadow.
    function automatic int field_lsb(input int idx, input int jw, input int nf);
        return (nf - 1 - idx) * jw;
    endfunction

endpackage

// File: rtl/jump_cfg_loader_cfg_field_check.sv
// Zero-or-one-hot legality test for one jump field.
module cfg_field_check #(
    parameter int W = 5
) (
    input  logic [W-1:0] field,
    output logic         legal
);

    // Clearing the lowest set bit leaves zero only for zero or one-hot values.
    assign legal = ((field & (field - W'(1))) == '0);

endmodule

// File: rtl/jump_cfg_loader.sv
// Bit-serial loader, validator and start sequencer for the five-state jump FSM.
module jump_cfg_loader
    import jump_cfg_pkg::*;
#(
    parameter int JW = 5,
    parameter int NF = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          sdata,
    input  logic          sstrobe,
    output logic [JW-1:0] jump1,
    output logic [JW-1:0] jump2,
    output logic [JW-1:0] jump3,
    output logic [JW-1:0] jump4,
    output logic [JW-1:0] jump5,
    output logic          ok,
    output logic          fsm_reset,
    output logic          loading,
    output logic          cfg_err
);

    localparam int BITS = JW * NF;
    localparam int CW   = $clog2(BITS);

    state_t                 state, state_n;
    logic [CW-1:0]          cnt;
    logic [BITS-1:0]        shadow;
    logic [NF-1:0][JW-1:0]  fields;
    logic [NF-1:0][JW-1:0]  jump_q;
    logic [NF-1:0]          legal;
    logic                   all_legal;
    logic                   clr;
    logic                   shift_en;
    logic                   last_bit;

    genvar g;
    generate
        for (g = 0; g < NF; g++) begin : g_field
            assign fields[g] = shadow[field_lsb(g, JW, NF) +: JW];
            cfg_field_check #(.W(JW)) u_chk (
                .field (fields[g]),
                .legal (legal[g])
            );
        end
    endgenerate

    assign all_legal = &legal;

    // CHECK and ARM ignore load_start, so a restart can only come from these three states.
    assign clr      = load_start && (state == ST_IDLE || state == ST_SHIFT || state == ST_RUN);
    assign shift_en = (state == ST_SHIFT) && sstrobe && !load_start;
    assign last_bit = (cnt == CW'(BITS - 1));

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (load_start) state_n = ST_SHIFT;
            ST_SHIFT: if (shift_en && last_bit) state_n = ST_CHECK;
            ST_CHECK: state_n = all_legal ? ST_ARM : ST_IDLE;
            ST_ARM:   state_n = ST_RUN;
            ST_RUN:   if (load_start) state_n = ST_SHIFT;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shadow  <= '0;
            jump_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_n;
            if (clr) begin
                cnt     <= '0;
                shadow  <= '0;
                cfg_err <= 1'b0;
            end else if (shift_en) begin
                shadow <= {shadow[BITS-2:0], sdata};
                if (!last_bit) cnt <= cnt + CW'(1);
            end
            if (state == ST_CHECK) begin
                if (all_legal) jump_q <= fields;
                else           cfg_err <= 1'b1;
            end
        end
    end

    assign ok        = (state == ST_ARM);
    assign fsm_reset = (state == ST_SHIFT) || (state == ST_CHECK);
    assign loading   = (state == ST_SHIFT);

    // Output ports are fixed at five fields; NF is expected to stay at its default.
    assign jump1 = jump_q[0];
    assign jump2 = jump_q[1];
    assign jump3 = jump_q[2];
    assign jump4 = jump_q[3];
    assign jump5 = jump_q[4];

endmodule

// File: tb/tb_jump_cfg_loader.sv
// Scoreboard bench for jump_cfg_loader: directed tables, monitor checks every ok / cfg_err event.
module tb_jump_cfg_loader;

    logic       clk = 1'b0;
    logic       reset, load_start, sdata, sstrobe;
    logic [4:0] jump1, jump2, jump3, jump4, jump5;
    logic       ok, fsm_reset, loading, cfg_err;

    localparam logic [24:0] T1  = {5{5'b00001}};
    localparam logic [24:0] T2  = {5'b00010, 5'b00100, 5'b10000, 5'b00100, 5'b00100};
    localparam logic [24:0] BAD = {5'b00001, 5'b00011, 5'b00001, 5'b00001, 5'b00001};
    localparam logic [24:0] T4  = {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00000};
    localparam logic [24:0] T6  = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

    typedef struct {
        bit          is_err;
        logic [24:0] tbl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gap_drop;

    jump_cfg_loader #(.JW(5), .NF(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .sdata      (sdata),
        .sstrobe    (sstrobe),
        .jump1      (jump1),
        .jump2      (jump2),
        .jump3      (jump3),
        .jump4      (jump4),
        .jump5      (jump5),
        .ok         (ok),
        .fsm_reset  (fsm_reset),
        .loading    (loading),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [24:0] cur_tbl();
        return {jump1, jump2, jump3, jump4, jump5};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sstrobe = 1'b1;
        sdata   = b;
        cyc();
        sstrobe = 1'b0;
    endtask

    task automatic send_table(input logic [24:0] tbl, input int gap);
        for (int i = 24; i >= 0; i--) begin
            send_bit(tbl[i]);
            if (i != 0) begin
                for (int k = 0; k < gap; k++) begin
                    cyc();
                    if (!loading) gap_drop++;
                end
            end
        end
    endtask

    // Monitor: every ok pulse or cfg_err rise is one DUT response.
    initial begin
        bit   err_prev;
        exp_t e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ok === 1'b1 || (cfg_err === 1'b1 && !err_prev)) begin
                if (q.size() == 0) begin
                    chk("unexpected_ok", 32'(ok), 32'd0);
                    chk("unexpected_err", 32'(cfg_err && !err_prev), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_ok", 32'(ok), 32'(!e.is_err));
                    chk("resp_cfg_err", 32'(cfg_err), 32'(e.is_err));
                    chk("resp_table", 32'(cur_tbl()), 32'(e.tbl));
                end
            end
            err_prev = (cfg_err === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_start = 1'b0; sdata = 1'b0; sstrobe = 1'b0;
        repeat (2) cyc();
        chk("rst_table", 32'(cur_tbl()), 32'd0);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_fsm_reset", 32'(fsm_reset), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        cyc();

        // Back-to-back good table.
        start();
        chk("t1_loading", 32'(loading), 32'd1);
        chk("t1_fsm_reset", 32'(fsm_reset), 32'd1);
        q.push_back('{is_err: 1'b0, tbl: T1});
        send_table(T1, 0);
        chk("t1_check_ok", 32'(ok), 32'd0);
        chk("t1_check_fsm_reset", 32'(fsm_reset), 32'd1);
        chk("t1_check_loading", 32'(loading), 32'd0);
        cyc();
        chk("t1_arm_ok", 32'(ok), 32'd1);
        chk("t1_arm_fsm_reset", 32'(fsm_reset), 32'd0);
        chk("t1_arm_table", 32'(cur_tbl()), 32'(T1));
        chk("t1_arm_cfg_err", 32'(cfg_err), 32'd0);
        cyc();
        chk("t1_run_ok", 32'(ok), 32'd0);

        // Gapped strobes, reload from RUN.
        start();
        gap_drop = 0;
        q.push_back('{is_err: 1'b0, tbl: T2});
        send_table(T2, 2);
        chk("t2_loading_in_gaps", 32'(gap_drop), 32'd0);
        cyc();
        chk("t2_arm_ok", 32'(ok), 32'd1);
        chk("t2_arm_table", 32'(cur_tbl()), 32'(T2));
        cyc();

        // Illegal field: rejected, previous table retained.
        start();
        q.push_back('{is_err: 1'b1, tbl: T2});
        send_table(BAD, 0);
        cyc();
        chk("bad_cfg_err", 32'(cfg_err), 32'd1);
        chk("bad_ok", 32'(ok), 32'd0);
        chk("bad_table_kept", 32'(cur_tbl()), 32'(T2));
        chk("bad_idle_loading", 32'(loading), 32'd0);
        chk("bad_idle_fsm_reset", 32'(fsm_reset), 32'd0);
        cyc();
        chk("bad_ok_later", 32'(ok), 32'd0);

        // Restart mid-load; the bit strobed with load_start is discarded.
        start();
        chk("restart_err_cleared", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        load_start = 1'b1; sstrobe = 1'b1; sdata = 1'b1;
        cyc();
        load_start = 1'b0; sstrobe = 1'b0;
        chk("restart_loading", 32'(loading), 32'd1);
        q.push_back('{is_err: 1'b0, tbl: T4});
        send_table(T4, 0);
        cyc();
        chk("restart_ok", 32'(ok), 32'd1);
        chk("restart_table", 32'(cur_tbl()), 32'(T4));
        cyc();

        // Reset mid-SHIFT, then trailing strobes must not start anything.
        start();
        for (int i = 0; i < 12; i++) send_bit(T6[24-i]);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_table", 32'(cur_tbl()), 32'd0);
        chk("midrst_fsm_reset", 32'(fsm_reset), 32'd0);
        chk("midrst_loading", 32'(loading), 32'd0);
        chk("midrst_ok", 32'(ok), 32'd0);
        for (int i = 0; i < 13; i++) send_bit(T6[12-i]);
        repeat (4) cyc();
        chk("midrst_after_table", 32'(cur_tbl()), 32'd0);
        chk("midrst_after_fsm_reset", 32'(fsm_reset), 32'd0);

        // Strobes in RUN are ignored; load_start from RUN re-enters SHIFT.
        start();
        q.push_back('{is_err: 1'b0, tbl: T6});
        send_table(T6, 0);
        cyc();
        chk("t6_arm_ok", 32'(ok), 32'd1);
        cyc();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        chk("run_table_held", 32'(cur_tbl()), 32'(T6));
        chk("run_loading", 32'(loading), 32'd0);
        chk("run_fsm_reset", 32'(fsm_reset), 32'd0);
        chk("run_ok", 32'(ok), 32'd0);
        start();
        chk("reload_fsm_reset", 32'(fsm_reset), 32'd1);
        chk("reload_loading", 32'(loading), 32'd1);
        repeat (3) cyc();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
